rmii_rx_deframer: RTL and testbench
===================================

# rmii_rx_deframer

Receive-direction RMII deframer for the 100 Mb/s Ethernet PHY link: the counterpart of the camera-to-Ethernet transmit path. It samples the PHY RX0/RX1/CRS_DV pins, strips preamble/SFD, and assembles dibits into bytes. It checks the IEEE 802.3 FCS and reports per-frame status (CRC, length, alignment). It sits directly behind the PHY pins in the top-level netlist and feeds the command/ACK handler.

## Interface

Parameters:
- MAX_FRAME_BYTES, 1518: maximum accepted byte count, DA through FCS inclusive.
- MIN_FRAME_BYTES, 64: minimum accepted byte count, DA through FCS inclusive.

Ports:
- In_CLK_50 input 1: 50 MHz RMII reference clock; the only clock.
- In_Reset_N input 1: asynchronous, active-low reset.
- In_PHY_RX0 input 1: RMII RXD[0].
- In_PHY_RX1 input 1: RMII RXD[1].
- In_PHY_CRS input 1: RMII CRS_DV.
- Out_RX_Data output 8: received byte. Holds its value between Valid pulses.
- Out_RX_Valid output 1: one-cycle pulse per byte.
- Out_RX_SOF output 1: high together with Valid for the first byte after SFD.
- Out_RX_EOF output 1: one-cycle end-of-frame pulse. Status outputs are valid while it is high.
- Out_RX_CRC_OK output 1: FCS residue matched. Held until the next EOF.
- Out_RX_Err output 1: frame bad (CRC, short, long, or misaligned). Held until the next EOF.
- Out_RX_Length output 11: accepted byte count, including FCS, saturating at MAX_FRAME_BYTES+1. Held until the next EOF.

## Operation

Input stage:
- Dibit = {RX1,RX0}. Transmission order is LSB first, so byte = {d3,d2,d1,d0}, with d0 received first.
- Inputs are registered once (stage S0), then delayed one more cycle (stage S1).
- The S1 dibit is *accepted* if crs1=1 or crs0=1. This absorbs the RMII CRS_DV toggling after carrier loss.
- End of carrier = crs1=0 and crs0=0.

State machine (IDLE, PREAMBLE, DATA, DROP, END):
- IDLE:
  - accepted dibit 01 -> PREAMBLE;
  - 00 stays in IDLE;
  - any other dibit -> DROP (silent).
- PREAMBLE:
  - 01 or 00 stays in PREAMBLE;
  - 11 (SFD) -> DATA. On entry: clear dibit counter and byte counter, set CRC = 0xFFFFFFFF, arm SOF.
  - 10 -> DROP (silent);
  - end of carrier -> IDLE. No EOF is issued.
- DATA:
  - Each accepted dibit updates the CRC (2 bits) and shifts into the byte register.
  - On every 4th dibit: emit the byte, increment the length.
  - When the byte count would exceed MAX_FRAME_BYTES: set length to MAX+1, flag long, go to DROP (loud). No further Valid pulses.
  - End of carrier -> END.
- DROP:
  - Wait for end of carrier.
  - Loud drop -> END.
  - Silent drop -> IDLE, with no EOF.
- END:
  - Pulse EOF for one cycle and update the status outputs, then go to IDLE.

Status:
- CRC: reflected polynomial 0xEDB88320, LSB-first update.
- CRC_OK = (CRC register == 0xDEBB20E3) after the last accepted dibit.
- Misaligned = dibit count mod 4 != 0 at end. The partial byte is discarded and is not emitted.
- Err = !CRC_OK | (length < MIN_FRAME_BYTES) | long | misaligned.
- FCS bytes are emitted on Out_RX_Data. Stripping the FCS is the consumer's responsibility.

Reset:
- Asynchronous. All outputs go to 0 and the state goes to IDLE immediately.
- After release with CRS high mid-frame, the resumed stream is handled by the IDLE rules. In the normal case it produces no SOF, Valid, or EOF until the next clean preamble.

## Timing

- Reset values: Out_RX_Data=0, Valid=0, SOF=0, EOF=0, CRC_OK=0, Err=0, Length=0.
- Byte latency: the 4th dibit of a byte is sampled at pin edge t. Valid is high during the cycle following edge t+2.
- Valid pulses are spaced at least 4 cycles apart.
- EOF timing: the second consecutive low CRS sample at S0 is taken at edge e. EOF is high for exactly one cycle, starting at edge e+2.
- EOF is never coincident with Valid and always comes after the final byte's Valid.
- CRC_OK, Err, and Length update on the same edge that raises EOF.
- Back-to-back frames: an IPG of at least 2 cycles with CRS low is sufficient. The next frame's preamble is accepted the cycle after END.

## Test plan

1. 7x0x55 + 0xD5, then 60 bytes 0x00..0x3B plus the correct FCS -> 64 Valid pulses; SOF with Data=0x00; EOF with CRC_OK=1, Err=0, Length=64.
2. Same as 1 with bit 0 of byte 10 flipped -> 64 Valid pulses; EOF with CRC_OK=0, Err=1, Length=64.
3. Same as 1, but CRS_DV is driven low on the first dibit of every nibble during the last 2 bytes -> output identical to test 1.
4. 1600-byte frame -> exactly 1518 Valid pulses; single EOF after carrier drop with Err=1, Length=1519.
5. Frame from test 1 plus one extra dibit before carrier drop -> 64 Valid pulses; EOF with Err=1, Length=64. Separately, a preamble containing dibit 10 -> no SOF, no Valid, no EOF.
6. In_Reset_N asserted during byte 20 of the frame from test 1 and released while CRS is still high -> all outputs 0 during reset; no Valid or EOF for the rest of that frame; the next clean frame decodes exactly as in test 1.

Source files
------------

// File: rtl/rmii_rx_deframer_if.sv
// Receive byte stream and per-frame status from the RMII deframer to its consumer.
interface rmii_rx_deframer_if;
    logic [7:0]  Out_RX_Data;
    logic        Out_RX_Valid;
    logic        Out_RX_SOF;
    logic        Out_RX_EOF;
    logic        Out_RX_CRC_OK;
    logic        Out_RX_Err;
    logic [10:0] Out_RX_Length;

    modport master (
        output Out_RX_Data, Out_RX_Valid, Out_RX_SOF, Out_RX_EOF,
        output Out_RX_CRC_OK, Out_RX_Err, Out_RX_Length
    );

    modport slave (
        input Out_RX_Data, Out_RX_Valid, Out_RX_SOF, Out_RX_EOF,
        input Out_RX_CRC_OK, Out_RX_Err, Out_RX_Length
    );
endinterface

// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: strips preamble/SFD, assembles dibits into bytes,
// checks the Ethernet FCS and reports CRC/length/alignment status per frame.
module rmii_rx_deframer #(
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int MIN_FRAME_BYTES = 64
) (
    input  logic               In_CLK_50,
    input  logic               In_Reset_N,
    input  logic               In_PHY_RX0,
    input  logic               In_PHY_RX1,
    input  logic               In_PHY_CRS,
    rmii_rx_deframer_if.master rx
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] MAX_LEN     = 11'(MAX_FRAME_BYTES);
    localparam logic [10:0] MIN_LEN     = 11'(MIN_FRAME_BYTES);
    localparam logic [10:0] LONG_LEN    = 11'(MAX_FRAME_BYTES + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA     = 3'd2,
        ST_DROP     = 3'd3,
        ST_END      = 3'd4
    } state_t;

    function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic b);
        logic [31:0] shifted;
        shifted = {1'b0, crc[31:1]};
        if (crc[0] ^ b) begin
            return shifted ^ CRC_POLY;
        end else begin
            return shifted;
        end
    endfunction

    // Bit 0 of the dibit is first on the wire.
    function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] dibit);
        return crc32_bit(crc32_bit(crc, dibit[0]), dibit[1]);
    endfunction

    logic [1:0]  s0_dibit_r, s1_dibit_r;
    logic        s0_crs_r, s1_crs_r;
    state_t      state_r, state_s;
    logic [31:0] crc_r, crc_s;
    logic [5:0]  shift_r, shift_s;
    logic [1:0]  dcnt_r, dcnt_s;
    logic [10:0] bcnt_r, bcnt_s;
    logic        long_r, long_s;
    logic        loud_r, loud_s;
    logic        sof_arm_r, sof_arm_s;
    logic [7:0]  data_r, data_s;
    logic        valid_r, valid_s;
    logic        sof_r, sof_s;
    logic        eof_r, eof_s;
    logic        crc_ok_r, crc_ok_s;
    logic        err_r, err_s;
    logic [10:0] len_r, len_s;
    logic        accepted_s;
    logic        crc_match_s;

    // Two-stage pin pipeline; S0 carrier lets a late CRS_DV toggle keep S1 accepted.
    always_ff @(posedge In_CLK_50 or negedge In_Reset_N) begin
        if (!In_Reset_N) begin
            s0_dibit_r <= 2'b00;
            s0_crs_r   <= 1'b0;
            s1_dibit_r <= 2'b00;
            s1_crs_r   <= 1'b0;
        end else begin
            s0_dibit_r <= {In_PHY_RX1, In_PHY_RX0};
            s0_crs_r   <= In_PHY_CRS;
            s1_dibit_r <= s0_dibit_r;
            s1_crs_r   <= s0_crs_r;
        end
    end

    // Next-state and datapath decode for the deframing FSM.
    always_comb begin
        accepted_s  = s1_crs_r | s0_crs_r;
        crc_match_s = (crc_r == CRC_RESIDUE);
        state_s     = state_r;
        crc_s       = crc_r;
        shift_s     = shift_r;
        dcnt_s      = dcnt_r;
        bcnt_s      = bcnt_r;
        long_s      = long_r;
        loud_s      = loud_r;
        sof_arm_s   = sof_arm_r;
        data_s      = data_r;
        valid_s     = 1'b0;
        sof_s       = 1'b0;
        eof_s       = 1'b0;
        crc_ok_s    = crc_ok_r;
        err_s       = err_r;
        len_s       = len_r;
        case (state_r)
            ST_IDLE: begin
                if (accepted_s) begin
                    case (s1_dibit_r)
                        2'b01:   state_s = ST_PREAMBLE;
                        2'b00:   state_s = ST_IDLE;
                        default: begin
                            state_s = ST_DROP;
                            loud_s  = 1'b0;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (!accepted_s) begin
                    state_s = ST_IDLE;
                end else begin
                    case (s1_dibit_r)
                        2'b11: begin
                            state_s   = ST_DATA;
                            dcnt_s    = 2'd0;
                            bcnt_s    = 11'd0;
                            crc_s     = CRC_INIT;
                            sof_arm_s = 1'b1;
                            long_s    = 1'b0;
                        end
                        2'b10: begin
                            state_s = ST_DROP;
                            loud_s  = 1'b0;
                        end
                        default: state_s = ST_PREAMBLE;
                    endcase
                end
            end
            ST_DATA: begin
                if (!accepted_s) begin
                    state_s = ST_END;
                end else begin
                    crc_s   = crc32_dibit(crc_r, s1_dibit_r);
                    shift_s = {s1_dibit_r, shift_r[5:2]};
                    dcnt_s  = dcnt_r + 2'd1;
                    if (dcnt_r == 2'd3) begin
                        if (bcnt_r == MAX_LEN) begin
                            bcnt_s  = LONG_LEN;
                            long_s  = 1'b1;
                            loud_s  = 1'b1;
                            state_s = ST_DROP;
                        end else begin
                            data_s    = {s1_dibit_r, shift_r};
                            valid_s   = 1'b1;
                            sof_s     = sof_arm_r;
                            sof_arm_s = 1'b0;
                            bcnt_s    = bcnt_r + 11'd1;
                        end
                    end else begin
                        bcnt_s = bcnt_r;
                    end
                end
            end
            ST_DROP: begin
                if (!accepted_s) begin
                    state_s = loud_r ? ST_END : ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end
            ST_END: begin
                eof_s    = 1'b1;
                crc_ok_s = crc_match_s;
                len_s    = bcnt_r;
                err_s    = !crc_match_s | (bcnt_r < MIN_LEN) | long_r | (dcnt_r != 2'd0);
                state_s  = ST_IDLE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge In_CLK_50 or negedge In_Reset_N) begin
        if (!In_Reset_N) begin
            state_r   <= ST_IDLE;
            crc_r     <= 32'h0000_0000;
            shift_r   <= 6'd0;
            dcnt_r    <= 2'd0;
            bcnt_r    <= 11'd0;
            long_r    <= 1'b0;
            loud_r    <= 1'b0;
            sof_arm_r <= 1'b0;
            data_r    <= 8'h00;
            valid_r   <= 1'b0;
            sof_r     <= 1'b0;
            eof_r     <= 1'b0;
            crc_ok_r  <= 1'b0;
            err_r     <= 1'b0;
            len_r     <= 11'd0;
        end else begin
            state_r   <= state_s;
            crc_r     <= crc_s;
            shift_r   <= shift_s;
            dcnt_r    <= dcnt_s;
            bcnt_r    <= bcnt_s;
            long_r    <= long_s;
            loud_r    <= loud_s;
            sof_arm_r <= sof_arm_s;
            data_r    <= data_s;
            valid_r   <= valid_s;
            sof_r     <= sof_s;
            eof_r     <= eof_s;
            crc_ok_r  <= crc_ok_s;
            err_r     <= err_s;
            len_r     <= len_s;
        end
    end

    assign rx.Out_RX_Data   = data_r;
    assign rx.Out_RX_Valid  = valid_r;
    assign rx.Out_RX_SOF    = sof_r;
    assign rx.Out_RX_EOF    = eof_r;
    assign rx.Out_RX_CRC_OK = crc_ok_r;
    assign rx.Out_RX_Err    = err_r;
    assign rx.Out_RX_Length = len_r;

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Self-checking bench for rmii_rx_deframer: directed and random frames driven
// on the RMII pins, compared against a frame-level reference model.
module tb_rmii_rx_deframer;

    localparam int MAX_B = 1518;
    localparam int MIN_B = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx0 = 1'b0;
    logic rx1 = 1'b0;
    logic crs = 1'b0;

    always #10 clk = ~clk;

    rmii_rx_deframer_if rx_if ();

    rmii_rx_deframer #(.MAX_FRAME_BYTES(MAX_B), .MIN_FRAME_BYTES(MIN_B)) dut (
        .In_CLK_50  (clk),
        .In_Reset_N (rst_n),
        .In_PHY_RX0 (rx0),
        .In_PHY_RX1 (rx1),
        .In_PHY_CRS (crs),
        .rx         (rx_if)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int nb_since = 0;
    int proto_err = 0;
    int min_gap = 1000;
    int last_valid_cyc = -1000;

    logic [7:0] tx_bytes[$];
    logic [7:0] exp_bytes[$], got_bytes[$], exp_sof[$], got_sof[$];
    int         exp_len[$], got_len[$], exp_nb[$], got_nb[$], exp_cyc[$], got_cyc[$];
    logic       exp_err[$], got_err[$], exp_ok[$], got_ok[$];
    bit         exp_ok_chk[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: collects bytes and per-EOF status records.
    initial forever begin
        @(negedge clk);
        if (!rst_n) nb_since = 0;
        if (rx_if.Out_RX_Valid) begin
            got_bytes.push_back(rx_if.Out_RX_Data);
            nb_since++;
            if (cyc - last_valid_cyc < min_gap) min_gap = cyc - last_valid_cyc;
            last_valid_cyc = cyc;
        end
        if (rx_if.Out_RX_SOF) begin
            if (rx_if.Out_RX_Valid) got_sof.push_back(rx_if.Out_RX_Data);
            else proto_err++;
        end
        if (rx_if.Out_RX_EOF) begin
            if (rx_if.Out_RX_Valid) proto_err++;
            got_len.push_back(int'(rx_if.Out_RX_Length));
            got_err.push_back(rx_if.Out_RX_Err);
            got_ok.push_back(rx_if.Out_RX_CRC_OK);
            got_nb.push_back(nb_since);
            got_cyc.push_back(cyc);
            nb_since = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] d, input logic c);
        @(negedge clk);
        rx0 = d[0];
        rx1 = d[1];
        crs = c;
    endtask

    // Ethernet FCS of the first n bytes of tx_bytes (standard reflected CRC-32).
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, tx_bytes[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic append_fcs();
        logic [31:0] f;
        f = fcs_of(tx_bytes.size());
        for (int k = 0; k < 4; k++) tx_bytes.push_back(f[8*k +: 8]);
    endtask

    task automatic build_t1();
        tx_bytes.delete();
        for (int i = 0; i < 60; i++) tx_bytes.push_back(8'(i));
        append_fcs();
    endtask

    task automatic send_frame(input int extra, input bit toggle, input bit bad_pre,
                              input int ipg, input int rst_at, input int rel_at);
        logic [1:0]  dq[$];
        bit          cq[$];
        logic [7:0]  b;
        logic [1:0]  xd;
        logic [31:0] fcs_rx;
        int n, ne, drv_cyc, nrst;
        bit is_long, aligned, fcs_ok;
        n = tx_bytes.size();
        drv_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            b = (i == 7) ? 8'hD5 : 8'h55;
            for (int k = 0; k < 4; k++) begin
                dq.push_back(b[2*k +: 2]);
                cq.push_back(1'b1);
            end
        end
        if (bad_pre) dq[9] = 2'b10;
        for (int i = 0; i < n; i++) begin
            b = tx_bytes[i];
            for (int k = 0; k < 4; k++) begin
                dq.push_back(b[2*k +: 2]);
                cq.push_back(!(toggle && (i >= n - 2) && (k == 0 || k == 2)));
            end
        end
        for (int e = 0; e < extra; e++) begin
            xd = 2'($urandom_range(0, 3));
            dq.push_back(xd);
            cq.push_back(1'b1);
        end
        for (int i = 0; i < dq.size(); i++) begin
            drive(dq[i], cq[i]);
            if (i == dq.size() - 1) drv_cyc = cyc;
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_data", rx_if.Out_RX_Data, 0);
                check("rst_valid", rx_if.Out_RX_Valid, 0);
                check("rst_sof", rx_if.Out_RX_SOF, 0);
                check("rst_eof", rx_if.Out_RX_EOF, 0);
                check("rst_crc_ok", rx_if.Out_RX_CRC_OK, 0);
                check("rst_err", rx_if.Out_RX_Err, 0);
                check("rst_length", rx_if.Out_RX_Length, 0);
            end
            if (i == rel_at) rst_n = 1'b1;
        end
        for (int i = 0; i < ipg; i++) drive(2'b00, 1'b0);

        // Reference model at frame level.
        if (bad_pre) begin
            // silently discarded: nothing expected
        end else if (rst_at >= 0) begin
            nrst = (rst_at - 34) / 4;
            for (int i = 0; i < nrst; i++) exp_bytes.push_back(tx_bytes[i]);
            if (nrst > 0) exp_sof.push_back(tx_bytes[0]);
        end else begin
            is_long = (n > MAX_B);
            ne = is_long ? MAX_B : n;
            aligned = (extra % 4 == 0);
            fcs_ok = 1'b0;
            if (n >= 4) begin
                fcs_rx = {tx_bytes[n-1], tx_bytes[n-2], tx_bytes[n-3], tx_bytes[n-4]};
                fcs_ok = (fcs_rx == fcs_of(n - 4));
            end
            for (int i = 0; i < ne; i++) exp_bytes.push_back(tx_bytes[i]);
            if (ne > 0) exp_sof.push_back(tx_bytes[0]);
            exp_len.push_back(is_long ? MAX_B + 1 : n);
            exp_err.push_back(is_long || (n < MIN_B) || !aligned || !fcs_ok);
            exp_ok.push_back(fcs_ok);
            exp_ok_chk.push_back(!is_long && aligned);
            exp_nb.push_back(ne);
            exp_cyc.push_back(drv_cyc + 5);
        end
    endtask

    task automatic compare_frames(input string tag);
        int mism, n;
        check({tag, " byte_count"}, got_bytes.size(), exp_bytes.size());
        mism = 0;
        n = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
        for (int i = 0; i < n; i++) if (got_bytes[i] !== exp_bytes[i]) mism++;
        check({tag, " byte_mismatches"}, mism, 0);
        check({tag, " sof_count"}, got_sof.size(), exp_sof.size());
        n = (got_sof.size() < exp_sof.size()) ? got_sof.size() : exp_sof.size();
        for (int i = 0; i < n; i++) check({tag, " sof_data"}, got_sof[i], exp_sof[i]);
        check({tag, " eof_count"}, got_len.size(), exp_len.size());
        n = (got_len.size() < exp_len.size()) ? got_len.size() : exp_len.size();
        for (int i = 0; i < n; i++) begin
            check({tag, " length"}, got_len[i], exp_len[i]);
            check({tag, " err"}, got_err[i], exp_err[i]);
            if (exp_ok_chk[i]) check({tag, " crc_ok"}, got_ok[i], exp_ok[i]);
            check({tag, " bytes_before_eof"}, got_nb[i], exp_nb[i]);
            check({tag, " eof_cycle"}, got_cyc[i], exp_cyc[i]);
        end
        check({tag, " protocol_errors"}, proto_err, 0);
        check({tag, " valid_gap_ge4"}, (min_gap >= 4), 1);
        exp_bytes.delete(); got_bytes.delete(); exp_sof.delete(); got_sof.delete();
        exp_len.delete(); got_len.delete(); exp_err.delete(); got_err.delete();
        exp_ok.delete(); got_ok.delete(); exp_ok_chk.delete();
        exp_nb.delete(); got_nb.delete(); exp_cyc.delete(); got_cyc.delete();
    endtask

    initial begin
        int len, bit_ix;
        repeat (3) @(negedge clk);
        check("reset_data", rx_if.Out_RX_Data, 0);
        check("reset_valid", rx_if.Out_RX_Valid, 0);
        check("reset_sof", rx_if.Out_RX_SOF, 0);
        check("reset_eof", rx_if.Out_RX_EOF, 0);
        check("reset_crc_ok", rx_if.Out_RX_CRC_OK, 0);
        check("reset_err", rx_if.Out_RX_Err, 0);
        check("reset_length", rx_if.Out_RX_Length, 0);
        rst_n = 1'b1;
        repeat (4) drive(2'b00, 1'b0);

        build_t1();
        send_frame(0, 1'b0, 1'b0, 12, -1, -1);
        compare_frames("t1_good");
        check("t1_held_length", rx_if.Out_RX_Length, 64);
        check("t1_held_crc_ok", rx_if.Out_RX_CRC_OK, 1);
        check("t1_held_err", rx_if.Out_RX_Err, 0);

        build_t1();
        tx_bytes[10] = tx_bytes[10] ^ 8'h01;
        send_frame(0, 1'b0, 1'b0, 12, -1, -1);
        compare_frames("t2_badcrc");

        build_t1();
        send_frame(0, 1'b1, 1'b0, 12, -1, -1);
        compare_frames("t3_crs_toggle");

        tx_bytes.delete();
        for (int i = 0; i < 1600; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
        send_frame(0, 1'b0, 1'b0, 12, -1, -1);
        compare_frames("t4_long");

        build_t1();
        send_frame(1, 1'b0, 1'b0, 12, -1, -1);
        compare_frames("t5_misaligned");

        build_t1();
        send_frame(0, 1'b0, 1'b1, 12, -1, -1);
        compare_frames("t5_bad_preamble");

        // Random frames with short inter-packet gaps, some corrupted or misaligned.
        for (int f = 0; f < 6; f++) begin
            tx_bytes.delete();
            len = $urandom_range(40, 120);
            for (int i = 0; i < len; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
            append_fcs();
            if ($urandom_range(0, 2) == 0) begin
                bit_ix = $urandom_range(0, 8 * len - 1);
                tx_bytes[bit_ix / 8] = tx_bytes[bit_ix / 8] ^ (8'h01 << (bit_ix % 8));
            end
            send_frame(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                       1'b0, 1'b0, $urandom_range(2, 5), -1, -1);
        end
        repeat (10) drive(2'b00, 1'b0);
        compare_frames("random");

        build_t1();
        send_frame(0, 1'b0, 1'b0, 12, 114, 120);
        build_t1();
        send_frame(0, 1'b0, 1'b0, 12, -1, -1);
        compare_frames("t6_reset_midframe");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
